// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and
// sizing of the shared down-counter.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  // Timer holds N-1 for the longest phase, so clog2 of the largest count suffices.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned TIMER_W_DEFAULT = timer_width(16, 65536, 1024);

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a stable lock, then releases system reset;
// retries on lock loss or lock timeout and counts both events.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  input  logic             soft_reset,
  output logic             pll_areset,
  output logic             sys_reset_n,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int unsigned TIMER_W = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [TIMER_W-1:0] RST_LOAD    = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LOAD     = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LOAD = TIMER_W'(STABLE_CYCLES - 1);

  pll_state_e         state_q;
  logic [TIMER_W-1:0] timer_q;
  logic               pll_areset_q;
  logic               sys_reset_n_q;
  logic               ready_q;
  logic [CNT_W-1:0]   lock_loss_q;
  logic [CNT_W-1:0]   timeout_q;
  logic               locked_s;
  logic               timer_zero;

  sync2 u_lock_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  assign timer_zero = (timer_q == '0);

  // Outputs are loaded on the same edge as the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= PLL_RST;
      timer_q       <= RST_LOAD;
      pll_areset_q  <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      lock_loss_q   <= '0;
      timeout_q     <= '0;
    end else if (soft_reset) begin
      state_q       <= PLL_RST;
      timer_q       <= RST_LOAD;
      pll_areset_q  <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (timer_zero) begin
            state_q      <= WAIT_LOCK;
            timer_q      <= TO_LOAD;
            pll_areset_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= STABLE;
            timer_q <= STABLE_LOAD;
          end else if (timer_zero) begin
            state_q      <= PLL_RST;
            timer_q      <= RST_LOAD;
            pll_areset_q <= 1'b1;
            if (timeout_q != '1) timeout_q <= timeout_q + 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            timer_q <= TO_LOAD;
          end else if (timer_zero) begin
            state_q       <= RUN;
            timer_q       <= '0;
            sys_reset_n_q <= 1'b1;
            ready_q       <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q       <= PLL_RST;
            timer_q       <= RST_LOAD;
            pll_areset_q  <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            if (lock_loss_q != '1) lock_loss_q <= lock_loss_q + 1'b1;
          end
        end
        default: begin
          state_q       <= PLL_RST;
          timer_q       <= RST_LOAD;
          pll_areset_q  <= 1'b1;
          sys_reset_n_q <= 1'b0;
          ready_q       <= 1'b0;
        end
      endcase
    end
  end

  assign state         = state_q;
  assign pll_areset    = pll_areset_q;
  assign sys_reset_n   = sys_reset_n_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lock_loss_q;
  assign timeout_cnt   = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short cycle parameters.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_reset;
  logic       pll_areset;
  logic       sys_reset_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;
  logic [7:0] timeout_cnt;

  int unsigned n_tests;
  int unsigned n_fail;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .CNT_W          (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .soft_reset    (soft_reset),
    .pll_areset    (pll_areset),
    .sys_reset_n   (sys_reset_n),
    .ready         (ready),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_cnt   (timeout_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Counts negedge samples, starting now, while pll_areset stays high.
  task automatic count_areset(output int n);
    n = 0;
    while (pll_areset && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_state(input logic [1:0] st, output int n);
    n = 0;
    while (state == st && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int lim, output logic ok);
    int n;
    n = 0;
    while (state != st && n < lim) begin
      @(negedge clk);
      n++;
    end
    ok = (state == st);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_state", state, PLL_RST);
    check_eq("rst_areset", pll_areset, 1);
    check_eq("rst_sysrst", sys_reset_n, 0);
    check_eq("rst_ready", ready, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int   n;
    logic ok;
    n_tests = 0;
    n_fail  = 0;

    // Basic bring-up
    do_reset();
    count_areset(n);
    check_eq("t1_areset_len", n, 4);
    repeat (3) @(negedge clk);
    pll_locked = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sys_reset_n && n < 100);
    check_eq("t1_release_lat", n, 11);
    check_eq("t1_state_run", state, RUN);
    check_eq("t1_ready", ready, 1);
    check_eq("t1_lockloss", lock_loss_cnt, 0);
    check_eq("t1_timeout", timeout_cnt, 0);

    // Repeated lock timeouts
    do_reset();
    for (int i = 0; i < 3; i++) begin
      count_areset(n);
      check_eq("t2_areset_len", n, 4);
      count_state(WAIT_LOCK, n);
      check_eq("t2_wait_len", n, 20);
      check_eq("t2_sysrst_low", sys_reset_n, 0);
    end
    check_eq("t2_timeout_cnt", timeout_cnt, 3);
    check_eq("t2_state", state, PLL_RST);

    // Lock seen on the same edge the timeout expires
    do_reset();
    count_areset(n);
    check_eq("tie_areset_len", n, 4);
    repeat (17) @(negedge clk);
    pll_locked = 1'b1;
    count_state(WAIT_LOCK, n);
    check_eq("tie_wait_tail", n, 3);
    check_eq("tie_state", state, STABLE);
    check_eq("tie_timeout", timeout_cnt, 0);

    // Lock drop during STABLE
    do_reset();
    count_areset(n);
    pll_locked = 1'b1;
    wait_state(STABLE, 50, ok);
    check_eq("t3_reach_stable", ok, 1);
    repeat (4) @(negedge clk);
    pll_locked = 1'b0;
    count_state(STABLE, n);
    check_eq("t3_stable_tail", n, 3);
    check_eq("t3_back_wait", state, WAIT_LOCK);
    pll_locked = 1'b1;
    count_state(WAIT_LOCK, n);
    check_eq("t3_wait_len", n, 3);
    count_state(STABLE, n);
    check_eq("t3_stable_full", n, 8);
    check_eq("t3_run", state, RUN);
    check_eq("t3_timeout", timeout_cnt, 0);
    check_eq("t3_sysrst", sys_reset_n, 1);

    // One-cycle lock glitch in RUN
    pll_locked = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      pll_locked = 1'b1;
    end while (sys_reset_n && n < 50);
    check_eq("t4_sysrst_lat", n, 3);
    check_eq("t4_lockloss", lock_loss_cnt, 1);
    count_areset(n);
    check_eq("t4_areset_len", n, 4);
    count_state(WAIT_LOCK, n);
    check_eq("t4_wait_len", n, 1);
    count_state(STABLE, n);
    check_eq("t4_stable_len", n, 8);
    check_eq("t4_run", state, RUN);

    // Soft reset pulse in RUN
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    check_eq("t5_state", state, PLL_RST);
    check_eq("t5_areset", pll_areset, 1);
    check_eq("t5_sysrst", sys_reset_n, 0);
    check_eq("t5_ready", ready, 0);
    check_eq("t5_lockloss", lock_loss_cnt, 1);
    count_areset(n);
    check_eq("t5_areset_len", n, 4);
    count_state(WAIT_LOCK, n);
    count_state(STABLE, n);
    check_eq("t5_stable_len", n, 8);
    check_eq("t5_run", state, RUN);

    // Soft reset held 10 cycles
    soft_reset = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pll_areset) n++;
    end
    check_eq("t5_hold_high", n, 10);
    soft_reset = 1'b0;
    count_areset(n);
    check_eq("t5_hold_tail", n, 4);
    wait_state(RUN, 50, ok);
    check_eq("t5_rerun", ok, 1);

    // Soft reset on the same edge a lock drop is seen
    pll_locked = 1'b0;
    repeat (2) @(negedge clk);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    pll_locked = 1'b1;
    check_eq("combo_state", state, PLL_RST);
    check_eq("combo_lockloss", lock_loss_cnt, 1);

    // 300 lock losses: counter saturates
    for (int i = 0; i < 300; i++) begin
      wait_state(RUN, 100, ok);
      check_eq("t6_reach_run", ok, 1);
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      repeat (3) @(negedge clk);
      if (i == 99) check_eq("t6_mid_count", lock_loss_cnt, 101);
    end
    check_eq("t6_saturated", lock_loss_cnt, 255);

    // Async reset mid-STABLE
    wait_state(STABLE, 100, ok);
    check_eq("t7_reach_stable", ok, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t7_state", state, PLL_RST);
    check_eq("t7_areset", pll_areset, 1);
    check_eq("t7_sysrst", sys_reset_n, 0);
    check_eq("t7_ready", ready, 0);
    check_eq("t7_lockloss", lock_loss_cnt, 0);
    check_eq("t7_timeout", timeout_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
